// File: rtl/playback_controller.sv
// rtl/playback_controller.sv - track selector / playback state machine for the music player
// Optional feature macro: PLAYBACK_SHUFFLE_EN (shuffle input plus LFSR-driven song_end selection).
module playback_controller #(
    parameter int N_TRACKS      = 4,
    parameter int SEL_W         = 2,
    parameter int RESTART_TICKS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play_pause,
    input  logic             prox,
    input  logic             prev,
    input  logic             song_end,
    input  logic             loop,
`ifdef PLAYBACK_SHUFFLE_EN
    input  logic             shuffle,
`endif
    output logic [SEL_W-1:0] select,
    output logic             start,
    output logic             playing
);

    localparam int               EL_W = $clog2(RESTART_TICKS + 1);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_TRACKS - 1);
    localparam logic [EL_W-1:0]  SAT  = EL_W'(RESTART_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_PAUSE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_select;
    logic [SEL_W-1:0] w_select_nxt;
    logic [SEL_W-1:0] w_sel_inc;
    logic [SEL_W-1:0] w_sel_dec;
    logic [EL_W-1:0]  r_elapsed;
    logic             r_pp_q;
    logic             r_nx_q;
    logic             r_pv_q;
    logic             r_se_q;
    logic             r_start;
    logic             r_playing;
    logic             w_pp_raw;
    logic             w_nx_raw;
    logic             w_pv_raw;
    logic             w_nx;
    logic             w_pv;
    logic             w_pp;
    logic             w_se;
    logic             w_restart;

    assign w_pp_raw = play_pause & ~r_pp_q;
    assign w_nx_raw = prox & ~r_nx_q;
    assign w_pv_raw = prev & ~r_pv_q;
    assign w_se     = song_end & ~r_se_q;

    // next+prev together cancel; any navigation button swallows play_pause
    assign w_nx = w_nx_raw & ~w_pv_raw;
    assign w_pv = w_pv_raw & ~w_nx_raw;
    assign w_pp = w_pp_raw & ~w_nx_raw & ~w_pv_raw;

    assign w_sel_inc = (r_select >= LAST) ? '0 : r_select + SEL_W'(1);
    assign w_sel_dec = (r_select == '0) ? LAST : r_select - SEL_W'(1);
    assign w_restart = (r_elapsed >= SAT);

`ifdef PLAYBACK_SHUFFLE_EN
    localparam int SW1 = SEL_W + 1;

    logic [7:0]       r_lfsr;
    logic [SW1-1:0]   w_shuf_sum;
    logic [SEL_W-1:0] w_sel_shuf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    // offset 1..N-1 from the current track, so the sum stays below 2*N and one subtract wraps it
    assign w_shuf_sum = {1'b0, r_select} + SW1'(1) + SW1'(r_lfsr % 8'(N_TRACKS - 1));
    assign w_sel_shuf = (w_shuf_sum >= SW1'(N_TRACKS)) ? SEL_W'(w_shuf_sum - SW1'(N_TRACKS))
                                                       : SEL_W'(w_shuf_sum);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_select_nxt = r_select;
        case (r_state)
            S_IDLE: begin
                if (w_nx) begin
                    w_select_nxt = w_sel_inc;
                end else if (w_pv) begin
                    w_select_nxt = w_sel_dec;
                end else if (w_pp) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (w_nx) begin
                    w_select_nxt = w_sel_inc;
                    w_state_nxt  = S_LOAD;
                end else if (w_pv) begin
                    if (!w_restart) begin
                        w_select_nxt = w_sel_dec;
                    end
                    w_state_nxt = S_LOAD;
                end else if (w_pp) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_se) begin
`ifdef PLAYBACK_SHUFFLE_EN
                    if (shuffle) begin
                        w_select_nxt = w_sel_shuf;
                        w_state_nxt  = S_LOAD;
                    end else
`endif
                    if (r_select < LAST) begin
                        w_select_nxt = w_sel_inc;
                        w_state_nxt  = S_LOAD;
                    end else begin
                        w_select_nxt = '0;
                        w_state_nxt  = loop ? S_LOAD : S_IDLE;
                    end
                end
            end
            S_PAUSE: begin
                if (w_nx) begin
                    w_select_nxt = w_sel_inc;
                    w_state_nxt  = S_LOAD;
                end else if (w_pv) begin
                    w_select_nxt = w_sel_dec;
                    w_state_nxt  = S_LOAD;
                end else if (w_pp) begin
                    w_state_nxt = S_PLAY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_select  <= '0;
            r_start   <= 1'b0;
            r_playing <= 1'b0;
            r_pp_q    <= 1'b0;
            r_nx_q    <= 1'b0;
            r_pv_q    <= 1'b0;
            r_se_q    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_select  <= w_select_nxt;
            r_start   <= (w_state_nxt == S_LOAD);
            r_playing <= (w_state_nxt == S_PLAY);
            r_pp_q    <= play_pause;
            r_nx_q    <= prox;
            r_pv_q    <= prev;
            r_se_q    <= song_end;
        end
    end

    // elapsed is cleared while loading and frozen outside PLAY
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_elapsed <= '0;
        end else if (r_state == S_LOAD) begin
            r_elapsed <= '0;
        end else if (r_state == S_PLAY && r_elapsed != SAT) begin
            r_elapsed <= r_elapsed + EL_W'(1);
        end
    end

    assign select  = r_select;
    assign start   = r_start;
    assign playing = r_playing;

endmodule

// File: tb/tb_playback_controller.sv
// tb/tb_playback_controller.sv - self-checking bench for playback_controller (4-track and 3-track builds)
module tb_playback_controller;

    localparam int R      = 8;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_PLAY = 2;
    localparam int M_PAUS = 3;

    logic       clk;
    logic       reset;
    logic       play_pause;
    logic       prox;
    logic       prev;
    logic       song_end;
    logic       loop;
`ifdef PLAYBACK_SHUFFLE_EN
    logic       shuffle;
`endif
    logic [1:0] w_sel     [2];
    logic       w_start   [2];
    logic       w_playing [2];

    int vectors;
    int miscompares;

    int       nt   [2] = '{4, 3};
    int       m_st [2];
    int       m_sel[2];
    int       m_el [2];
    bit [3:0] m_q;
    bit [7:0] m_lfsr;

    playback_controller #(.N_TRACKS(4), .SEL_W(2), .RESTART_TICKS(R)) u_dut4 (
        .clk(clk), .reset(reset), .play_pause(play_pause), .prox(prox), .prev(prev),
        .song_end(song_end), .loop(loop),
`ifdef PLAYBACK_SHUFFLE_EN
        .shuffle(shuffle),
`endif
        .select(w_sel[0]), .start(w_start[0]), .playing(w_playing[0])
    );

    playback_controller #(.N_TRACKS(3), .SEL_W(2), .RESTART_TICKS(R)) u_dut3 (
        .clk(clk), .reset(reset), .play_pause(play_pause), .prox(prox), .prev(prev),
        .song_end(song_end), .loop(loop),
`ifdef PLAYBACK_SHUFFLE_EN
        .shuffle(shuffle),
`endif
        .select(w_sel[1]), .start(w_start[1]), .playing(w_playing[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]  = M_IDLE;
            m_sel[k] = 0;
            m_el[k]  = 0;
        end
        m_q    = '0;
        m_lfsr = 8'hA5;
    endtask

    // Reference behaviour at one rising edge, applied to both track counts.
    task automatic model_edge();
        bit e_pp, e_nx, e_pv, e_se, nx, pv, pp, shuf;
        shuf = 1'b0;
`ifdef PLAYBACK_SHUFFLE_EN
        shuf = shuffle;
`endif
        if (!reset) begin
            model_reset();
            return;
        end
        e_pp = play_pause && !m_q[0];
        e_nx = prox && !m_q[1];
        e_pv = prev && !m_q[2];
        e_se = song_end && !m_q[3];
        m_q  = {song_end, prev, prox, play_pause};
        nx   = e_nx && !e_pv;
        pv   = e_pv && !e_nx;
        pp   = e_pp && !e_nx && !e_pv;
        for (int k = 0; k < 2; k++) begin
            int n;
            int old_el;
            n = nt[k];
            case (m_st[k])
                M_IDLE: begin
                    if (nx)      m_sel[k] = (m_sel[k] + 1) % n;
                    else if (pv) m_sel[k] = (m_sel[k] + n - 1) % n;
                    else if (pp) m_st[k] = M_LOAD;
                end
                M_LOAD: begin
                    m_st[k] = M_PLAY;
                    m_el[k] = 0;
                end
                M_PLAY: begin
                    old_el = m_el[k];
                    if (m_el[k] < R) m_el[k]++;
                    if (nx) begin
                        m_sel[k] = (m_sel[k] + 1) % n;
                        m_st[k]  = M_LOAD;
                    end else if (pv) begin
                        if (old_el < R) m_sel[k] = (m_sel[k] + n - 1) % n;
                        m_st[k] = M_LOAD;
                    end else if (pp) begin
                        m_st[k] = M_PAUS;
                    end else if (e_se) begin
                        if (shuf) begin
                            m_sel[k] = (m_sel[k] + 1 + int'(m_lfsr) % (n - 1)) % n;
                            m_st[k]  = M_LOAD;
                        end else if (m_sel[k] < n - 1) begin
                            m_sel[k]++;
                            m_st[k] = M_LOAD;
                        end else begin
                            m_sel[k] = 0;
                            m_st[k]  = loop ? M_LOAD : M_IDLE;
                        end
                    end
                end
                default: begin
                    if (nx) begin
                        m_sel[k] = (m_sel[k] + 1) % n;
                        m_st[k]  = M_LOAD;
                    end else if (pv) begin
                        m_sel[k] = (m_sel[k] + n - 1) % n;
                        m_st[k]  = M_LOAD;
                    end else if (pp) begin
                        m_st[k] = M_PLAY;
                    end
                end
            endcase
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #3;
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (w_sel[k] !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_select dut%0d got %0d want 0", k, w_sel[k]);
            end
            vectors++;
            if (w_start[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_start dut%0d got %b want 0", k, w_start[k]);
            end
            vectors++;
            if (w_playing[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_playing dut%0d got %b want 0", k, w_playing[k]);
            end
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_idle_nav();
        bit saw_start;
        saw_start = 1'b0;
        prox = 1'b1; tick(); saw_start |= w_start[0] | w_start[1];
        vectors++;
        if (w_sel[0] !== 2'd1) begin
            miscompares++;
            $display("FAIL idle_next_1 got %0d want 1", w_sel[0]);
        end
        prox = 1'b0; tick(); saw_start |= w_start[0] | w_start[1];
        prox = 1'b1; tick(); saw_start |= w_start[0] | w_start[1];
        prox = 1'b0; tick(); saw_start |= w_start[0] | w_start[1];
        vectors++;
        if (w_sel[0] !== 2'd2 || w_sel[1] !== 2'd2) begin
            miscompares++;
            $display("FAIL idle_next_2 got %0d/%0d want 2/2", w_sel[0], w_sel[1]);
        end
        vectors++;
        if (saw_start !== 1'b0 || w_playing[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet start_seen=%b playing=%b want 0/0", saw_start, w_playing[0]);
        end
        prox = 1'b1; tick();
        prox = 1'b0; tick();
        vectors++;
        if (w_sel[0] !== 2'd3 || w_sel[1] !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_next_wrap got %0d/%0d want 3/0", w_sel[0], w_sel[1]);
        end
        prev = 1'b1; tick();
        prev = 1'b0; tick();
        vectors++;
        if (w_sel[0] !== 2'd2 || w_sel[1] !== 2'd2) begin
            miscompares++;
            $display("FAIL idle_prev_wrap got %0d/%0d want 2/2", w_sel[0], w_sel[1]);
        end
        prev = 1'b1; tick();
        prev = 1'b0; tick();
    endtask

    task automatic test_play_start();
        bit bad;
        bad = 1'b0;
        play_pause = 1'b1; tick();
        vectors++;
        if (w_start[0] !== 1'b1 || w_playing[0] !== 1'b0 || w_sel[0] !== 2'd1) begin
            miscompares++;
            $display("FAIL play_load start=%b playing=%b sel=%0d want 1/0/1", w_start[0], w_playing[0], w_sel[0]);
        end
        tick();
        vectors++;
        if (w_start[0] !== 1'b0 || w_playing[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL play_enter start=%b playing=%b want 0/1", w_start[0], w_playing[0]);
        end
        repeat (9) begin
            tick();
            if (w_start[0] !== 1'b0 || w_playing[0] !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL play_hold got glitch=%b want 0", bad);
        end
        play_pause = 1'b0; tick();
    endtask

    task automatic test_prev_rules();
        prev = 1'b1; tick();
        vectors++;
        if (w_sel[0] !== 2'd1 || w_start[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL prev_restart_long sel=%0d start=%b want 1/1", w_sel[0], w_start[0]);
        end
        prev = 1'b0; tick();
        tick();
        tick();
        prev = 1'b1; tick();
        vectors++;
        if (w_sel[0] !== 2'd0 || w_start[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL prev_step_back sel=%0d start=%b want 0/1", w_sel[0], w_start[0]);
        end
        prev = 1'b0; tick();
        repeat (20) tick();
        prev = 1'b1; tick();
        vectors++;
        if (w_sel[0] !== 2'd0 || w_start[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL prev_restart sel=%0d start=%b want 0/1", w_sel[0], w_start[0]);
        end
        prev = 1'b0; tick();
    endtask

    task automatic test_song_end();
        prev = 1'b1; tick();
        prev = 1'b0; tick();
        loop = 1'b0; song_end = 1'b1; tick();
        vectors++;
        if (w_sel[0] !== 2'd0 || w_start[0] !== 1'b0 || w_playing[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL end_stop sel=%0d start=%b playing=%b want 0/0/0", w_sel[0], w_start[0], w_playing[0]);
        end
        song_end = 1'b0; tick();
        play_pause = 1'b1; tick();
        play_pause = 1'b0; tick();
        prev = 1'b1; tick();
        prev = 1'b0; tick();
        loop = 1'b1; song_end = 1'b1; tick();
        vectors++;
        if (w_sel[0] !== 2'd0 || w_start[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL end_loop sel=%0d start=%b want 0/1", w_sel[0], w_start[0]);
        end
        song_end = 1'b0; tick();
        vectors++;
        if (w_playing[0] !== 1'b1 || w_start[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL end_loop_play playing=%b start=%b want 1/0", w_playing[0], w_start[0]);
        end
        loop = 1'b0;
    endtask

    task automatic test_pause();
        play_pause = 1'b1; tick();
        vectors++;
        if (w_playing[0] !== 1'b0 || w_start[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL pause playing=%b start=%b want 0/0", w_playing[0], w_start[0]);
        end
        play_pause = 1'b0; tick();
        play_pause = 1'b1; tick();
        vectors++;
        if (w_playing[0] !== 1'b1 || w_start[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL resume playing=%b start=%b want 1/0", w_playing[0], w_start[0]);
        end
        play_pause = 1'b0; tick();
        prox = 1'b1; prev = 1'b1; tick();
        vectors++;
        if (w_sel[0] !== 2'd0 || w_start[0] !== 1'b0 || w_playing[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL both_nav sel=%0d start=%b playing=%b want 0/0/1", w_sel[0], w_start[0], w_playing[0]);
        end
        prox = 1'b0; prev = 1'b0; tick();
    endtask

    task automatic test_reset_in_load();
        prox = 1'b1; tick();
        prox = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (w_sel[k] !== 2'd0 || w_start[k] !== 1'b0 || w_playing[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d sel=%0d start=%b playing=%b want 0/0/0",
                         k, w_sel[k], w_start[k], w_playing[k]);
            end
        end
        reset = 1'b1;
        tick();
    endtask

`ifdef PLAYBACK_SHUFFLE_EN
    task automatic test_shuffle();
        int old_sel;
        shuffle = 1'b1;
        loop = 1'b0;
        play_pause = 1'b1; tick();
        play_pause = 1'b0; tick();
        repeat (20) begin
            old_sel = int'(w_sel[0]);
            song_end = 1'b1; tick();
            vectors++;
            if (int'(w_sel[0]) == old_sel || w_start[0] !== 1'b1 || w_sel[0] !== 2'(m_sel[0])) begin
                miscompares++;
                $display("FAIL shuffle sel=%0d prev_sel=%0d start=%b want new track %0d with start",
                         w_sel[0], old_sel, w_start[0], m_sel[0]);
            end
            song_end = 1'b0; tick();
        end
        shuffle = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if (c % 64 == 0) begin
                loop = 1'($urandom_range(0, 1));
`ifdef PLAYBACK_SHUFFLE_EN
                shuffle = 1'($urandom_range(0, 1));
`endif
            end
            play_pause = ($urandom_range(0, 15) == 0);
            prox       = ($urandom_range(0, 11) == 0);
            prev       = ($urandom_range(0, 11) == 0);
            song_end   = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 299) != 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (w_sel[k] !== 2'(m_sel[k])) begin
                    miscompares++;
                    $display("FAIL rand_select dut%0d cyc %0d got %0d want %0d", k, c, w_sel[k], m_sel[k]);
                end
                vectors++;
                if (w_start[k] !== (m_st[k] == M_LOAD)) begin
                    miscompares++;
                    $display("FAIL rand_start dut%0d cyc %0d got %b want %b", k, c, w_start[k], m_st[k] == M_LOAD);
                end
                vectors++;
                if (w_playing[k] !== (m_st[k] == M_PLAY)) begin
                    miscompares++;
                    $display("FAIL rand_playing dut%0d cyc %0d got %b want %b", k, c, w_playing[k], m_st[k] == M_PLAY);
                end
            end
        end
        reset = 1'b1;
        play_pause = 1'b0; prox = 1'b0; prev = 1'b0; song_end = 1'b0;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        play_pause  = 1'b0;
        prox        = 1'b0;
        prev        = 1'b0;
        song_end    = 1'b0;
        loop        = 1'b0;
`ifdef PLAYBACK_SHUFFLE_EN
        shuffle     = 1'b0;
`endif
        model_reset();
        test_reset();
        test_idle_nav();
        test_play_start();
        test_prev_rules();
        test_song_end();
        test_pause();
        test_reset_in_load();
`ifdef PLAYBACK_SHUFFLE_EN
        test_shuffle();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/playback_controller.md
Name: playback_controller

Overview:
- Sequences the music player's track selector and note sequencer.
- Turns play/pause, next and previous buttons plus the sequencer's end-of-song flag into a track index and a one-cycle start pulse.
- Tracks playback state (stopped / playing / paused) and elapsed time. This decides whether "previous" restarts the current song or steps back a track.
- Sits between the debounced button inputs and the song ROM/sequencer.

Parameters:
- N_TRACKS, 4, number of tracks; legal range 2..2^SEL_W.
- SEL_W, 2, width of track index.
- RESTART_TICKS, 8, elapsed PLAY cycles at or above which "prev" restarts the current song instead of stepping back.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- play_pause  input  1  level button; acts on rising edge.
- prox  input  1  level button; acts on rising edge.
- prev  input  1  level button; acts on rising edge.
- song_end  input  1  level from sequencer; acts on rising edge.
- loop  input  1  1 = wrap to track 0 at end of playlist; 0 = stop.
- select  output  SEL_W  current track index, registered.
- start  output  1  one-cycle pulse that (re)starts the sequencer on select.
- playing  output  1  high in PLAY state only.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, select=0, start=0, playing=0, elapsed=0.
  - All edge-detect registers cleared, so an input already high at release produces an edge on the first clock.
- Edge detect: evt = in & ~in_q, with in_q registered every clock. Holding a level never repeats an action.
- Latency: an event sampled at edge k updates select and state at edge k. start is high for the cycle following edge k.
- inc/dec are modulo N_TRACKS, correct for non-power-of-two:
  - N_TRACKS-1 increments to 0.
  - 0 decrements to N_TRACKS-1.
- States:
  - IDLE (playing=0):
    - play_pause -> LOAD.
    - prox -> select=inc, stay IDLE.
    - prev -> select=dec, stay IDLE.
    - song_end ignored.
  - LOAD (start=1, elapsed cleared):
    - Unconditionally -> PLAY next cycle.
    - Every event in the LOAD cycle is discarded.
  - PLAY (playing=1):
    - elapsed increments, saturating at RESTART_TICKS.
    - play_pause -> PAUSE.
    - prox -> select=inc, LOAD.
    - prev with elapsed >= RESTART_TICKS -> select unchanged, LOAD.
    - prev with elapsed < RESTART_TICKS -> select=dec, LOAD.
    - song_end, select < N_TRACKS-1 -> select=inc, LOAD.
    - song_end, select = N_TRACKS-1, loop=1 -> select=0, LOAD.
    - song_end, select = N_TRACKS-1, loop=0 -> select=0, IDLE (no start).
  - PAUSE (playing=0, elapsed held):
    - play_pause -> PLAY with no start pulse (resume).
    - prox -> select=inc, LOAD.
    - prev -> select=dec, LOAD; restart rule not applied.
    - song_end ignored.
- Simultaneous events, same cycle:
  - prox and prev together: both ignored.
  - prox or prev with play_pause: the button wins and play_pause is dropped.
  - prox with song_end in PLAY: a single inc only; prox semantics apply, so it always wraps regardless of loop.
- Mid-operation reset: immediately forces the reset values above; start is never left high.
- Outputs are Moore and registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: PLAYBACK_SHUFFLE_EN.
- Defined:
  - Adds input port shuffle (1 bit) after loop.
  - Adds an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset value 8'hA5, advancing every clock.
  - In PLAY with shuffle=1, song_end selects (select + 1 + (lfsr % (N_TRACKS-1))) % N_TRACKS, guaranteed different from the current track, then -> LOAD.
  - Never goes to IDLE; loop is ignored.
  - Buttons stay sequential.
- Undefined: no shuffle port, no LFSR; behaviour exactly as above.

Test Plan:
- Reset, prox pulse x2 in IDLE -> select 0->1->2, start never asserted, playing=0.
- play_pause pulse in IDLE -> start=1 for exactly one cycle, playing=1 from the next cycle; holding play_pause high 10 cycles causes no PAUSE.
- In PLAY on track 1: prev 3 cycles after start -> select=0 + start pulse; then hold PLAY 20 cycles, prev -> select stays 0 + start pulse (restart).
- song_end on track 3 with loop=0 -> select=0, IDLE, no start; repeat with loop=1 -> select=0, start pulse, playing stays 1.
- PAUSE then play_pause -> playing=1 with no start; prox+prev same cycle -> select unchanged; N_TRACKS=3 build: prox from 2 -> 0, prev from 0 -> 2.
- reset asserted during LOAD -> select=0, start=0, playing=0 immediately, without waiting for a clock; with PLAYBACK_SHUFFLE_EN and shuffle=1, 20 song_end events never repeat the current track and never reach IDLE.
